// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART receiver: parity modes, FSM state
// encoding and a constant-evaluable ceiling log2.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    // Ceiling log2; usable in parameter/localparam expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r++;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// Consumer-side bus of the buffered UART receiver.
//   master: receiver drives Data/ParityErr/FrameErr/Ready/Overrun/Level, takes Ack
//   slave : consumer side of the same signals
interface uart_rx_buffered_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) ();
    localparam int unsigned LEVEL_W = clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] Data;
    logic                 ParityErr;
    logic                 FrameErr;
    logic                 Ready;
    logic                 Ack;
    logic                 Overrun;
    logic [LEVEL_W-1:0]   Level;

    modport master (
        output Data, ParityErr, FrameErr, Ready, Overrun, Level,
        input  Ack
    );

    modport slave (
        input  Data, ParityErr, FrameErr, Ready, Overrun, Level,
        output Ack
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received words.
//   clk, rst_n     : clock, async active-low reset
//   push/push_data : write request and word (dropped when full unless popping)
//   pop            : advance head (ignored when empty)
//   head           : word at the head of the queue
//   full/empty     : occupancy flags; level: current occupancy
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [clog2(DEPTH):0]  level
);
    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    // Pointers carry one extra wrap bit; equal index with differing wrap bit means full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];

    // A pop frees the slot first, so a push into a full FIFO that is also popping succeeds.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// UART receiver with receive FIFO.
//   Clk, nReset : clock, async active-low reset
//   Rx          : serial line, idle high, asynchronous to Clk
//   bus         : consumer interface (Data/ParityErr/FrameErr/Ready/Ack/Overrun/Level)
// Rx is synchronised, majority-voted over three consecutive samples around the
// bit centre, framed by the FSM, and every completed word (including errored
// ones) is pushed into the FIFO as {FrameErr, ParityErr, Data}.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 30,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic               Clk,
    input  logic               nReset,
    input  logic               Rx,
    uart_rx_buffered_if.master bus
);
    localparam int unsigned TW = clog2(CLKS_PER_BIT);
    localparam int unsigned BW = clog2(DATA_BITS);
    localparam int unsigned EW = DATA_BITS + 2;
    localparam int unsigned LW = clog2(FIFO_DEPTH) + 1;

    localparam logic [TW-1:0] T_HALF    = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL    = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    rx_state_t            state, state_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic [BW-1:0]        bit_idx, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_err, par_nxt;
    logic                 frm_err, frm_nxt;
    logic                 stop_idx, stop_nxt;
    logic                 push_c;
    logic [EW-1:0]        entry_c;

    logic                 rx_meta, rx_sync, rx_h1, rx_h2;
    logic                 vote_c;
    logic                 tick_c;
    logic                 push_q;
    logic [EW-1:0]        entry_q;
    logic                 overrun_q;

    logic [EW-1:0]        head_c;
    logic                 full_c, empty_c, pop_c;
    logic [LW-1:0]        level_c;

    // Two-flop synchroniser plus two history taps for the vote; preset to idle-high.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_h1   <= 1'b1;
            rx_h2   <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
            rx_h1   <= rx_sync;
            rx_h2   <= rx_h1;
        end
    end

    assign vote_c = (rx_sync & rx_h1) | (rx_sync & rx_h2) | (rx_h1 & rx_h2);
    assign tick_c = (timer == '0);

    // State and datapath registers
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            stop_idx <= 1'b0;
            push_q   <= 1'b0;
            entry_q  <= '0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            bit_idx  <= bit_nxt;
            shreg    <= shreg_nxt;
            par_err  <= par_nxt;
            frm_err  <= frm_nxt;
            stop_idx <= stop_nxt;
            push_q   <= push_c;
            entry_q  <= entry_c;
        end
    end

    // Next-state logic: framing, bit timing and word assembly
    always_comb begin
        state_nxt = state;
        timer_nxt = tick_c ? timer : timer - TW'(1);
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        par_nxt   = par_err;
        frm_nxt   = frm_err;
        stop_nxt  = stop_idx;
        push_c    = 1'b0;
        entry_c   = entry_q;

        case (state)
            ST_IDLE: begin
                if (!rx_sync) begin
                    state_nxt = ST_START;
                    timer_nxt = T_HALF;
                    par_nxt   = 1'b0;
                    frm_nxt   = 1'b0;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    if (vote_c) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DATA;
                        timer_nxt = T_FULL;
                        bit_nxt   = '0;
                    end
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    shreg_nxt = {vote_c, shreg[DATA_BITS-1:1]};
                    timer_nxt = T_FULL;
                    if (bit_idx == BIT_LAST) begin
                        stop_nxt  = 1'b0;
                        state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_nxt = bit_idx + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick_c) begin
                    par_nxt   = ((^shreg) ^ vote_c) != (PARITY == PARITY_ODD);
                    timer_nxt = T_FULL;
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick_c) begin
                    if (!vote_c) frm_nxt = 1'b1;
                    if (stop_idx == STOP_LAST) begin
                        push_c    = 1'b1;
                        entry_c   = {frm_nxt, par_err, shreg};
                        // A low line after the last stop bit must not look like a new start.
                        state_nxt = vote_c ? ST_IDLE : ST_BREAK;
                    end else begin
                        stop_nxt  = stop_idx + 1'b1;
                        timer_nxt = T_FULL;
                    end
                end
            end
            ST_BREAK: begin
                if (rx_sync) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign pop_c = bus.Ack & ~empty_c;

    uart_rx_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (nReset),
        .push      (push_q),
        .push_data (entry_q),
        .pop       (pop_c),
        .head      (head_c),
        .full      (full_c),
        .empty     (empty_c),
        .level     (level_c)
    );

    // Overrun: word dropped because FIFO was full and nobody popped
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) overrun_q <= 1'b0;
        else         overrun_q <= push_q & full_c & ~pop_c;
    end

    // Head outputs are forced to zero while empty so stale storage never shows.
    assign bus.Ready                              = ~empty_c;
    assign {bus.FrameErr, bus.ParityErr, bus.Data} = empty_c ? '0 : head_c;
    assign bus.Level                              = level_c;
    assign bus.Overrun                            = overrun_q;
endmodule
